// File: rtl/pipe_pkg.sv
// Shared constants and payload types for the MIPS pipeline-stage buffers.
package pipe_pkg;

  localparam int unsigned MAX_PIPE_DEPTH = 8;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REGADDR_W  = 5;
  localparam int unsigned MEMTOREG_W = 3;

  // MEM/WB payload; pack into DATA_W = $bits(mewb_payload_t) at the instantiation.
  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [INSTR_W-1:0]    instr;
    logic [31:0]           alu_out;
    logic [31:0]           dm_rdata;
    logic [REGADDR_W-1:0]  rd_addr;
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic                  reg_write;
  } mewb_payload_t;

endpackage

// File: rtl/pipe_slice.sv
// One valid+data register slice; an empty or flushed slice always holds zero data.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = src_valid_i;
      data_d  = src_valid_i ? src_data_i : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-slice pipeline-stage register with valid/ready, bubble collapse and flush.
// Define PIPE_STAGE_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  load;
  logic [DATA_W-1:0] d [DEPTH];

  // Unrolled ready chain: slice i loads unless it and every slice after it are full
  // while the consumer stalls. Avoids a combinational self-loop through one vector.
  always_comb begin
    logic full_tail;
    load      = '0;
    full_tail = 1'b1;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      full_tail = full_tail & v[i];
      load[i]   = out_ready | !full_tail;
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_slice
    logic              src_valid;
    logic [DATA_W-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = v[i-1];
      assign src_data  = d[i-1];
    end

    pipe_slice #(
      .DATA_W (DATA_W)
    ) u_slice (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .load_i      (load[i]),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .valid_o     (v[i]),
      .data_o      (d[i])
    );
  end

  assign in_ready  = load[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Internal shifts conserve the item count, so only the two end transfers move it.
  logic             in_xfer, out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf (DATA_W=32, DEPTH=2): directed table,
// hand-written reset/latency sequence and a randomized run against a queue model.
module tb_pipe_stage_buf;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;
`endif

  pipe_stage_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] dat, input logic ordy,
                       input logic fl);
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] dat;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [31:0] dat, logic ordy, logic fl,
                              logic e_ir, logic e_ov, logic [31:0] e_od, int e_occ);
    vec_t r;
    r.iv = iv; r.dat = dat; r.ordy = ordy; r.fl = fl;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_occ = e_occ;
    return r;
  endfunction

  typedef struct {
    logic [31:0] data;
    int          acc;
  } item_t;

  vec_t  vecs[20];
  item_t q[$];
  int    last_dep;

  initial begin
    // Inputs, then outputs observed before the following edge.
    vecs[0]  = mk(1, 32'h1,  1, 0,  1, 0, 32'h0,  0);  // stream 1..4
    vecs[1]  = mk(1, 32'h2,  1, 0,  1, 0, 32'h0,  1);
    vecs[2]  = mk(1, 32'h3,  1, 0,  1, 1, 32'h1,  2);
    vecs[3]  = mk(1, 32'h4,  1, 0,  1, 1, 32'h2,  2);
    vecs[4]  = mk(0, 32'h0,  1, 0,  1, 1, 32'h3,  2);
    vecs[5]  = mk(0, 32'h0,  1, 0,  1, 1, 32'h4,  1);
    vecs[6]  = mk(0, 32'h0,  1, 0,  1, 0, 32'h0,  0);
    vecs[7]  = mk(1, 32'h5,  0, 0,  1, 0, 32'h0,  0);  // fill while stalled
    vecs[8]  = mk(1, 32'h6,  0, 0,  1, 0, 32'h0,  1);
    vecs[9]  = mk(1, 32'h7,  0, 0,  0, 1, 32'h5,  2);
    vecs[10] = mk(1, 32'h7,  1, 0,  1, 1, 32'h5,  2);  // emit and accept together
    vecs[11] = mk(0, 32'h0,  0, 0,  0, 1, 32'h6,  2);
    vecs[12] = mk(1, 32'h99, 0, 1,  0, 1, 32'h6,  2);  // flush while full
    vecs[13] = mk(1, 32'h11, 0, 0,  1, 0, 32'h0,  0);
    vecs[14] = mk(0, 32'h0,  0, 0,  1, 0, 32'h0,  1);  // bubble behind item
    vecs[15] = mk(1, 32'h22, 0, 0,  1, 1, 32'h11, 1);
    vecs[16] = mk(1, 32'h33, 0, 0,  0, 1, 32'h11, 2);
    vecs[17] = mk(0, 32'h0,  1, 0,  1, 1, 32'h11, 2);
    vecs[18] = mk(0, 32'h0,  1, 0,  1, 1, 32'h22, 1);
    vecs[19] = mk(0, 32'h0,  1, 0,  1, 0, 32'h0,  0);

    // Reset held, then first transfer and its latency.
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset occupancy", 32'(occupancy), 32'd0);
    reset = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    chk("post-reset in_ready", {31'b0, in_ready}, 32'd1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("latency edge1 out_valid", {31'b0, out_valid}, 32'd0);
    chk("latency edge1 occupancy", 32'(occupancy), 32'd1);
    step();
    chk("latency edge2 out_valid", {31'b0, out_valid}, 32'd1);
    chk("latency edge2 out_data", out_data, 32'hDEADBEEF);

    // Asynchronous reset mid-flight.
    drive(1'b1, 32'h1234, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("pre-async out_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("async reset out_data", out_data, 32'd0);
    chk("async reset occupancy", 32'(occupancy), 32'd0);
    step();
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].iv, vecs[i].dat, vecs[i].ordy, vecs[i].fl);
      #1;
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_od);
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      step();
    end

    // Randomized run: a queue of accepted items, each with its accept edge. An item
    // reaches the last slice DEPTH-1 edges after acceptance, but never before the edge
    // its predecessor left.
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    q.delete();
    last_dep = 0;
    for (int n = 0; n < 400; n++) begin
      logic        iv, ordy, fl, e_ir, e_ov;
      logic [31:0] dat, e_od;
      int          arrive;
      iv   = ($urandom_range(99) < 70);
      ordy = ($urandom_range(99) < 60);
      fl   = ($urandom_range(99) < 5);
      dat  = $urandom;
      drive(iv, dat, ordy, fl);
      #1;
      e_ir = !fl && !((q.size() == int'(DEPTH)) && !ordy);
      e_ov = 1'b0;
      if (q.size() > 0) begin
        arrive = q[0].acc + int'(DEPTH) - 1;
        if (last_dep > arrive) arrive = last_dep;
        e_ov = (cyc >= arrive);
      end
      e_od = e_ov ? q[0].data : 32'h0;
      chk("rand in_ready", {31'b0, in_ready}, {31'b0, e_ir});
      chk("rand out_valid", {31'b0, out_valid}, {31'b0, e_ov});
      chk("rand out_data", out_data, e_od);
      chk("rand occupancy", 32'(occupancy), 32'(q.size()));
      if (fl) begin
        q.delete();
      end else begin
        if (e_ov && ordy) begin
          void'(q.pop_front());
          last_dep = cyc + 1;
        end
        if (iv && e_ir) q.push_back('{data: dat, acc: cyc + 1});
      end
      step();
    end

`ifdef PIPE_STAGE_STATS_EN
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b1, 32'hA5, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stats stall_cnt", stall_cnt, 32'd3);
    chk("stats flush_cnt", flush_cnt, 32'd2);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    drive(1'b1, 32'h5A, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("stats stall_cnt saturate", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
